otter_id_stage: RTL and testbench

- Registered instruction-decode stage for the pipelined OTTER core. It sits between the IF/ID and ID/EX pipeline registers.
- Decodes the RV32I opcode, plus the M extension when it is enabled. Produces the ALU, register-file and memory controls and holds them in the ID/EX register.
- Detects load-use hazards and inserts one bubble per hazard. Honours downstream back-pressure and branch flushes.
- Adds illegal-instruction flagging and a saturating bubble counter, which the earlier combinational decoder lacked.

---
 rtl/otter_pkg.sv | 55 +++++
 rtl/otter_decode.sv | 101 ++++++++++
 rtl/otter_id_stage.sv | 113 +++++++++++
 tb/tb_otter_id_stage.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/otter_pkg.sv
// Shared types and encodings for the OTTER decode stage.
package otter_pkg;

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OP_IMM = 7'b0010011,
    OPC_OP     = 7'b0110011,
    OPC_SYSTEM = 7'b1110011
  } opcode_t;

  typedef enum logic [2:0] {
    F3_PRIV   = 3'b000,
    F3_CSRRW  = 3'b001,
    F3_CSRRS  = 3'b010,
    F3_CSRRC  = 3'b011,
    F3_CSRRWI = 3'b101,
    F3_CSRRSI = 3'b110,
    F3_CSRRCI = 3'b111
  } func3_sys_t;

  localparam logic [1:0] SRCB_REG   = 2'd0;
  localparam logic [1:0] SRCB_IMM_I = 2'd1;
  localparam logic [1:0] SRCB_IMM_S = 2'd2;
  localparam logic [1:0] SRCB_IMM_U = 2'd3;

  localparam logic [1:0] RF_SEL_PC4 = 2'd0;
  localparam logic [1:0] RF_SEL_CSR = 2'd1;
  localparam logic [1:0] RF_SEL_MEM = 2'd2;
  localparam logic [1:0] RF_SEL_ALU = 2'd3;

  localparam logic [3:0] ALU_FUN_LUI = 4'b1001;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       alu_srca;
    logic [1:0] alu_srcb;
    logic [4:0] alu_fun;
    logic [1:0] rf_wr_sel;
    logic       regwrite;
    logic       memwrite;
    logic       memread;
    logic [1:0] msize;
    logic       munsigned;
    logic       illegal;
  } decode_t;

endpackage

// File: rtl/otter_decode.sv
// Combinational RV32I(+M) decoder: instruction word -> control struct and
// source-register usage flags for hazard detection.
module otter_decode
  import otter_pkg::*;
#(
  parameter bit SUPPORT_M = 1'b0
) (
  input  logic [31:0] i_instr,
  output decode_t     o_dec,
  output logic        o_uses_rs1,
  output logic        o_uses_rs2
);

  opcode_t    w_op;
  logic [2:0] w_f3;
  logic [6:0] w_f7;
  logic       w_illegal;

  assign w_op = opcode_t'(i_instr[6:0]);
  assign w_f3 = i_instr[14:12];
  assign w_f7 = i_instr[31:25];

  always_comb begin
    o_dec           = '0;
    o_dec.rs1       = i_instr[19:15];
    o_dec.rs2       = i_instr[24:20];
    o_dec.rd        = i_instr[11:7];
    o_dec.msize     = w_f3[1:0];
    o_dec.munsigned = w_f3[2];
    o_dec.alu_srcb  = SRCB_REG;
    o_dec.rf_wr_sel = RF_SEL_ALU;
    o_dec.regwrite  = 1'b1;
    o_uses_rs1      = 1'b1;
    o_uses_rs2      = 1'b0;
    w_illegal       = 1'b0;
    case (w_op)
      OPC_LUI: begin
        o_dec.alu_srca = 1'b1;
        o_dec.alu_fun  = {1'b0, ALU_FUN_LUI};
        o_uses_rs1     = 1'b0;
      end
      OPC_AUIPC: begin
        o_dec.alu_srca = 1'b1;
        o_dec.alu_srcb = SRCB_IMM_U;
        o_uses_rs1     = 1'b0;
      end
      OPC_JAL: begin
        o_dec.alu_srcb  = SRCB_IMM_I;
        o_dec.rf_wr_sel = RF_SEL_PC4;
        o_uses_rs1      = 1'b0;
      end
      OPC_JALR: o_dec.rf_wr_sel = RF_SEL_PC4;
      OPC_BRANCH: begin
        o_dec.regwrite = 1'b0;
        o_uses_rs2     = 1'b1;
      end
      OPC_LOAD: begin
        o_dec.alu_srcb  = SRCB_IMM_I;
        o_dec.rf_wr_sel = RF_SEL_MEM;
        o_dec.memread   = 1'b1;
      end
      OPC_STORE: begin
        o_dec.alu_srcb = SRCB_IMM_S;
        o_dec.regwrite = 1'b0;
        o_dec.memwrite = 1'b1;
        o_uses_rs2     = 1'b1;
      end
      OPC_OP_IMM: begin
        o_dec.alu_srcb = SRCB_IMM_I;
        // only the shift-right immediate carries an alternate-op bit in func7
        o_dec.alu_fun  = {1'b0, (w_f3 == 3'b101) ? w_f7[5] : 1'b0, w_f3};
      end
      OPC_OP: begin
        o_uses_rs2    = 1'b1;
        o_dec.alu_fun = {1'b0, w_f7[5], w_f3};
        case (w_f7)
          7'b0000000: ;
          7'b0100000: w_illegal = !((w_f3 == 3'b000) || (w_f3 == 3'b101));
          7'b0000001: begin
            if (SUPPORT_M) o_dec.alu_fun = {2'b10, w_f3};
            else           w_illegal     = 1'b1;
          end
          default: w_illegal = 1'b1;
        endcase
      end
      OPC_SYSTEM: begin
        o_dec.rf_wr_sel = RF_SEL_CSR;
        o_dec.alu_fun   = {1'b0, ALU_FUN_LUI};
        o_uses_rs1      = !w_f3[2];
      end
      default: w_illegal = 1'b1;
    endcase
    if (w_illegal) begin
      o_dec.regwrite = 1'b0;
      o_dec.memwrite = 1'b0;
      o_dec.memread  = 1'b0;
    end
    o_dec.illegal = w_illegal;
  end

endmodule

// File: rtl/otter_id_stage.sv
// Registered decode stage: decoder, load-use hazard detection, ID/EX register
// and a saturating count of inserted bubbles.
module otter_id_stage
  import otter_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter bit SUPPORT_M = 1'b0,
  parameter int CNT_W     = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             if_valid,
  input  logic [31:0]      if_instr,
  input  logic [XLEN-1:0]  if_pc,
  input  logic             ex_ready,
  input  logic             flush,
  output logic             id_stall,
  output logic             dx_valid,
  output logic [XLEN-1:0]  dx_pc,
  output logic [31:0]      dx_instr,
  output logic [4:0]       dx_rs1,
  output logic [4:0]       dx_rs2,
  output logic [4:0]       dx_rd,
  output logic             dx_alu_srca,
  output logic [1:0]       dx_alu_srcb,
  output logic [4:0]       dx_alu_fun,
  output logic [1:0]       dx_rf_wr_sel,
  output logic             dx_regwrite,
  output logic             dx_memwrite,
  output logic             dx_memread,
  output logic [1:0]       dx_msize,
  output logic             dx_munsigned,
  output logic             dx_illegal,
  output logic [CNT_W-1:0] bubble_cnt
);

  decode_t            w_dec;
  logic               w_uses_rs1;
  logic               w_uses_rs2;
  logic               w_load_use;
  decode_t            r_dec;
  logic               r_valid;
  logic [XLEN-1:0]    r_pc;
  logic [31:0]        r_instr;
  logic [CNT_W-1:0]   r_bubble_cnt;

  otter_decode #(.SUPPORT_M(SUPPORT_M)) u_decode (
    .i_instr    (if_instr),
    .o_dec      (w_dec),
    .o_uses_rs1 (w_uses_rs1),
    .o_uses_rs2 (w_uses_rs2)
  );

  assign w_load_use = if_valid && r_valid && r_dec.memread && (r_dec.rd != 5'd0) &&
                      (((r_dec.rd == w_dec.rs1) && w_uses_rs1) ||
                       ((r_dec.rd == w_dec.rs2) && w_uses_rs2));
  assign id_stall   = (w_load_use || !ex_ready) && !flush;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_dec        <= '0;
      r_valid      <= 1'b0;
      r_pc         <= '0;
      r_instr      <= '0;
      r_bubble_cnt <= '0;
    end else if (flush) begin
      r_valid        <= 1'b0;
      r_dec.regwrite <= 1'b0;
      r_dec.memwrite <= 1'b0;
      r_dec.memread  <= 1'b0;
      r_dec.illegal  <= 1'b0;
    end else if (!ex_ready) begin
      // hold: EX has not consumed the current ID/EX contents
    end else if (w_load_use) begin
      r_valid        <= 1'b0;
      r_dec.regwrite <= 1'b0;
      r_dec.memwrite <= 1'b0;
      r_dec.memread  <= 1'b0;
      r_dec.illegal  <= 1'b0;
      if (r_bubble_cnt != '1) r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
    end else begin
      r_dec   <= w_dec;
      r_valid <= if_valid;
      r_pc    <= if_pc;
      r_instr <= if_instr;
      if (!if_valid) begin
        r_dec.regwrite <= 1'b0;
        r_dec.memwrite <= 1'b0;
        r_dec.memread  <= 1'b0;
        r_dec.illegal  <= 1'b0;
      end
    end
  end

  assign dx_valid     = r_valid;
  assign dx_pc        = r_pc;
  assign dx_instr     = r_instr;
  assign dx_rs1       = r_dec.rs1;
  assign dx_rs2       = r_dec.rs2;
  assign dx_rd        = r_dec.rd;
  assign dx_alu_srca  = r_dec.alu_srca;
  assign dx_alu_srcb  = r_dec.alu_srcb;
  assign dx_alu_fun   = r_dec.alu_fun;
  assign dx_rf_wr_sel = r_dec.rf_wr_sel;
  assign dx_regwrite  = r_dec.regwrite;
  assign dx_memwrite  = r_dec.memwrite;
  assign dx_memread   = r_dec.memread;
  assign dx_msize     = r_dec.msize;
  assign dx_munsigned = r_dec.munsigned;
  assign dx_illegal   = r_dec.illegal;
  assign bubble_cnt   = r_bubble_cnt;

endmodule

// File: tb/tb_otter_id_stage.sv
// Directed bench: base config (no M, 16-bit counter) and an M-enabled,
// 2-bit-counter instance share one stimulus stream.
module tb_otter_id_stage;

  localparam logic [31:0] I_ADD3   = 32'h002081B3; // add x3,x1,x2
  localparam logic [31:0] I_LW5    = 32'h0000A283; // lw  x5,0(x1)
  localparam logic [31:0] I_ADD6   = 32'h00228333; // add x6,x5,x2
  localparam logic [31:0] I_MUL3   = 32'h022081B3; // mul x3,x1,x2
  localparam logic [31:0] I_SW     = 32'h0020A223; // sw  x2,4(x1)
  localparam logic [31:0] I_LUI7   = 32'h123453B7; // lui x7,0x12345
  localparam logic [31:0] I_BAD    = 32'h0000007F; // undefined opcode
  localparam logic [31:0] I_LW0    = 32'h0000A003; // lw  x0,0(x1)
  localparam logic [31:0] I_ADD6X0 = 32'h00200333; // add x6,x0,x2

  logic        CLK = 1'b0;
  logic        RST, if_valid, ex_ready, flush;
  logic [31:0] if_instr, if_pc;

  logic        a_stall, a_valid, a_srca, a_rw, a_mw, a_mr, a_mu, a_ill;
  logic [31:0] a_pc, a_instr;
  logic [4:0]  a_rs1, a_rs2, a_rd, a_fun;
  logic [1:0]  a_srcb, a_rfsel, a_msize;
  logic [15:0] a_cnt;

  logic        b_stall, b_valid, b_srca, b_rw, b_mw, b_mr, b_mu, b_ill;
  logic [31:0] b_pc, b_instr;
  logic [4:0]  b_rs1, b_rs2, b_rd, b_fun;
  logic [1:0]  b_srcb, b_rfsel, b_msize;
  logic [1:0]  b_cnt;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  otter_id_stage #(.XLEN(32), .SUPPORT_M(1'b0), .CNT_W(16)) u_dut_a (
    .CLK(CLK), .RST(RST), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .ex_ready(ex_ready), .flush(flush), .id_stall(a_stall), .dx_valid(a_valid),
    .dx_pc(a_pc), .dx_instr(a_instr), .dx_rs1(a_rs1), .dx_rs2(a_rs2), .dx_rd(a_rd),
    .dx_alu_srca(a_srca), .dx_alu_srcb(a_srcb), .dx_alu_fun(a_fun),
    .dx_rf_wr_sel(a_rfsel), .dx_regwrite(a_rw), .dx_memwrite(a_mw),
    .dx_memread(a_mr), .dx_msize(a_msize), .dx_munsigned(a_mu),
    .dx_illegal(a_ill), .bubble_cnt(a_cnt)
  );

  otter_id_stage #(.XLEN(32), .SUPPORT_M(1'b1), .CNT_W(2)) u_dut_b (
    .CLK(CLK), .RST(RST), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .ex_ready(ex_ready), .flush(flush), .id_stall(b_stall), .dx_valid(b_valid),
    .dx_pc(b_pc), .dx_instr(b_instr), .dx_rs1(b_rs1), .dx_rs2(b_rs2), .dx_rd(b_rd),
    .dx_alu_srca(b_srca), .dx_alu_srcb(b_srcb), .dx_alu_fun(b_fun),
    .dx_rf_wr_sel(b_rfsel), .dx_regwrite(b_rw), .dx_memwrite(b_mw),
    .dx_memread(b_mr), .dx_msize(b_msize), .dx_munsigned(b_mu),
    .dx_illegal(b_ill), .bubble_cnt(b_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc);
    if_valid = 1'b1;
    if_instr = instr;
    if_pc    = pc;
  endtask

  initial begin
    RST = 1'b1; if_valid = 1'b0; if_instr = '0; if_pc = '0;
    ex_ready = 1'b1; flush = 1'b0;
    tick(); tick();
    check("rst_valid", a_valid, 0);
    check("rst_cnt", a_cnt, 0);
    check("rst_regwrite", a_rw, 0);
    check("rst_pc", a_pc, 0);
    RST = 1'b0;

    // plain R-type add
    drive(I_ADD3, 32'h100); tick();
    check("add_valid", a_valid, 1);
    check("add_fun", a_fun, 5'b00000);
    check("add_srcb", a_srcb, 0);
    check("add_rfsel", a_rfsel, 3);
    check("add_rw", a_rw, 1);
    check("add_regs", {a_rs1, a_rs2, a_rd}, {5'd1, 5'd2, 5'd3});
    check("add_pc", a_pc, 32'h100);

    // load followed by dependent add
    drive(I_LW5, 32'h104); tick();
    check("lw_mr", a_mr, 1);
    check("lw_srcb", a_srcb, 1);
    check("lw_rfsel", a_rfsel, 2);
    check("lw_msize", {a_msize, a_mu}, 3'b100);
    drive(I_ADD6, 32'h108); #1;
    check("lu_stall", a_stall, 1);
    tick();
    check("lu_bubble_valid", a_valid, 0);
    check("lu_bubble_mr", a_mr, 0);
    check("lu_cnt_a", a_cnt, 1);
    check("lu_cnt_b", b_cnt, 1);
    check("lu_release", a_stall, 0);
    tick();
    check("lu_dep_valid", a_valid, 1);
    check("lu_dep_rd", a_rd, 6);
    check("lu_dep_pc", a_pc, 32'h108);

    // M op: illegal without M, MUL with M
    drive(I_MUL3, 32'h10C); tick();
    check("mul_a_ill", a_ill, 1);
    check("mul_a_rw", a_rw, 0);
    check("mul_b_fun", b_fun, 5'b10000);
    check("mul_b_ill", b_ill, 0);
    check("mul_b_rw", b_rw, 1);

    drive(I_LUI7, 32'h110); tick();
    check("lui_fun", a_fun, 5'b01001);
    check("lui_srca", a_srca, 1);
    check("lui_rd", a_rd, 7);

    drive(I_BAD, 32'h114); tick();
    check("bad_ill", a_ill, 1);
    check("bad_rw", a_rw, 0);

    // flush beats load-use and back-pressure
    drive(I_LW5, 32'h118); tick();
    drive(I_ADD6, 32'h11C); ex_ready = 1'b0; flush = 1'b1; #1;
    check("fl_stall", a_stall, 0);
    tick();
    check("fl_valid", a_valid, 0);
    check("fl_mr", a_mr, 0);
    check("fl_cnt", a_cnt, 1);
    flush = 1'b0; ex_ready = 1'b1;

    // back-pressure holds ID/EX while sw waits in ID
    drive(I_ADD3, 32'h1F0); tick();
    drive(I_SW, 32'h200); ex_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_stall", a_stall, 1);
      tick();
      check("bp_hold", {a_valid, a_rd, a_pc}, {1'b1, 5'd3, 32'h1F0});
    end
    ex_ready = 1'b1; tick();
    check("sw_mw", a_mw, 1);
    check("sw_srcb", a_srcb, 2);
    check("sw_rw", a_rw, 0);
    check("sw_pc", a_pc, 32'h200);

    // load into x0 never stalls
    drive(I_LW0, 32'h204); tick();
    check("lw0_rw", a_rw, 1);
    drive(I_ADD6X0, 32'h208); #1;
    check("x0_stall", a_stall, 0);
    tick();
    check("x0_valid", a_valid, 1);
    check("x0_cnt", a_cnt, 1);

    // counter saturation on the 2-bit instance
    for (int k = 1; k <= 5; k++) begin
      drive(I_LW5, 32'h300); tick();
      drive(I_ADD6, 32'h304); tick(); tick();
      check("sat_cnt_a", a_cnt, 1 + k);
      check("sat_cnt_b", b_cnt, (1 + k > 3) ? 3 : 1 + k);
    end

    // reset while stalled releases the stall
    drive(I_LW5, 32'h400); tick();
    drive(I_ADD6, 32'h404); #1;
    check("rs_stall", a_stall, 1);
    RST = 1'b1; tick();
    check("rs_valid", a_valid, 0);
    check("rs_cnt_a", a_cnt, 0);
    check("rs_cnt_b", b_cnt, 0);
    check("rs_release", a_stall, 0);
    RST = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
